// File: rtl/digital_clock_core_if.sv
// Key-pulse inputs and time/display outputs of the digital clock core.
// master: the timekeeping core (drives time/display, receives keys).
// slave: the key source and display consumer.
interface digital_clock_core_if;
   logic        key_mode;
   logic        key_inc;
   logic [23:0] number_BCD;
   logic [2:0]  DTube_en;
   logic [2:0]  Twinkle_en;
   logic [1:0]  mode;
   logic        tick_1hz;

   modport master (
      input  key_mode, key_inc,
      output number_BCD, DTube_en, Twinkle_en, mode, tick_1hz
   );

   modport slave (
      output key_mode, key_inc,
      input  number_BCD, DTube_en, Twinkle_en, mode, tick_1hz
   );
endinterface

// File: rtl/digital_clock_core.sv
// Timekeeping core: CLK_DIV prescaler to 1 Hz, packed BCD HH:MM:SS, set-mode FSM (DIGITAL_CLOCK_HOUR12_EN selects 12-hour form).
// Latency: 1 cycle from key pulse to mode/Twinkle_en/number_BCD; first second CLK_DIV edges after reset or re-entering RUN.
// Backpressure: none; key pulses are consumed in the cycle they arrive, outputs are free-running registers.
module digital_clock_core #(
   parameter int CLK_DIV = 50_000_000
) (
   input logic                   clk,
   input logic                   rst_N,
   digital_clock_core_if.master  bus
);

   localparam int            CW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
`ifdef DIGITAL_CLOCK_HOUR12_EN
   localparam logic [7:0]    HOUR_RST = 8'h12;
`else
   localparam logic [7:0]    HOUR_RST = 8'h00;
`endif

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } mode_t;

   mode_t         r_mode;
   logic [CW-1:0] r_cnt;
   logic [7:0]    r_hour;
   logic [7:0]    r_min;
   logic [7:0]    r_sec;
   logic [2:0]    r_twinkle;
   logic          r_tick;

   logic          w_term;
   logic [7:0]    w_hour_nx;
   logic [7:0]    w_min_nx;
   logic [7:0]    w_sec_nx;
   mode_t         w_mode_nx;

   // Two-digit BCD increment wrapping 59 -> 00 (minutes and seconds).
   function automatic logic [7:0] f_inc60(input logic [7:0] v);
      if (v == 8'h59)
         return 8'h00;
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Two-digit BCD hour increment; wrap point depends on 12/24-hour build.
   function automatic logic [7:0] f_inc_hour(input logic [7:0] v);
`ifdef DIGITAL_CLOCK_HOUR12_EN
      if (v == 8'h12)
         return 8'h01;
`else
      if (v == 8'h23)
         return 8'h00;
`endif
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // One blink bit per field being edited; nothing blinks while running.
   function automatic logic [2:0] f_twinkle(input mode_t m);
      case (m)
         SET_H:   return 3'b100;
         SET_M:   return 3'b010;
         SET_S:   return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   // Running-second cascade: S carries into M, M carries into H.
   always_comb begin
      w_term    = (r_mode == RUN) && (r_cnt == CNT_MAX);
      w_sec_nx  = f_inc60(r_sec);
      w_min_nx  = (r_sec == 8'h59) ? f_inc60(r_min) : r_min;
      w_hour_nx = ((r_sec == 8'h59) && (r_min == 8'h59)) ? f_inc_hour(r_hour) : r_hour;
      w_mode_nx = mode_t'(r_mode + 2'd1);
   end

   // Mode FSM, prescaler and time registers; key_mode outranks key_inc,
   // and a second that expires on the same edge as key_mode still commits.
   always_ff @(posedge clk or posedge rst_N) begin
      if (rst_N) begin
         r_mode    <= RUN;
         r_cnt     <= '0;
         r_hour    <= HOUR_RST;
         r_min     <= 8'h00;
         r_sec     <= 8'h00;
         r_twinkle <= 3'b000;
         r_tick    <= 1'b0;
      end else begin
         // The pulse is suppressed when RUN is being left on this edge so
         // that tick_1hz is never seen high alongside a set mode.
         r_tick <= w_term & ~bus.key_mode;

         if ((r_mode == RUN) && !bus.key_mode)
            r_cnt <= w_term ? '0 : r_cnt + CW'(1);
         else
            r_cnt <= '0;

         if (w_term) begin
            r_hour <= w_hour_nx;
            r_min  <= w_min_nx;
            r_sec  <= w_sec_nx;
         end

         if (bus.key_mode) begin
            r_mode    <= w_mode_nx;
            r_twinkle <= f_twinkle(w_mode_nx);
         end else if (bus.key_inc) begin
            case (r_mode)
               SET_H:   r_hour <= f_inc_hour(r_hour);
               SET_M:   r_min  <= f_inc60(r_min);
               SET_S:   r_sec  <= f_inc60(r_sec);
               default: ;
            endcase
         end
      end
   end

   assign bus.number_BCD = {r_hour, r_min, r_sec};
   assign bus.DTube_en   = 3'b111;
   assign bus.Twinkle_en = r_twinkle;
   assign bus.mode       = r_mode;
   assign bus.tick_1hz   = r_tick;

endmodule

// File: doc/digital_clock_core.md
# digital_clock_core

Timekeeping and time-setting engine for the digital clock. Divides the system clock down to a 1 Hz tick, keeps hours/minutes/seconds in packed BCD, and runs a small set-mode state machine driven by two pre-debounced key pulses. Sits directly upstream of the clock display driver and feeds its `number_BCD`, `DTube_en` and `Twinkle_en` inputs.

## Interface
- `CLK_DIV`, default 50_000_000: system clocks per second; legal range ≥ 2.
- `clk` input 1: system clock.
- `rst_N` input 1: reset, asynchronous, active-high (asserted = 1 despite the name).
- `key_mode` input 1: one-cycle pulse that advances the mode.
- `key_inc` input 1: one-cycle pulse that increments the selected field in set modes.
- `number_BCD` output 24: `[23:20]` H tens, `[19:16]` H units, `[15:12]` M tens, `[11:8]` M units, `[7:4]` S tens, `[3:0]` S units.
- `DTube_en` output 3: digit-pair enable, bit2 = hours, bit1 = minutes, bit0 = seconds.
- `Twinkle_en` output 3: blink request, same bit mapping as `DTube_en`.
- `mode` output 2: 0 RUN, 1 SET_H, 2 SET_M, 3 SET_S.
- `tick_1hz` output 1: one-cycle pulse on each running-second advance.

## Operation
- Prescaler `cnt` counts 0..CLK_DIV-1 in RUN only. At the edge where `cnt == CLK_DIV-1`:
  - `cnt` returns to 0.
  - seconds advance and `tick_1hz` pulses.
- Time advance is a BCD cascade:
  - S 59→00 carries to M.
  - M 59→00 carries to H.
  - H 23→00 wraps.
  - Unit digits 9→0 carry to the tens digit. No digit ever holds a value > 9.
- Mode FSM:
  - `key_mode` steps RUN→SET_H→SET_M→SET_S→RUN.
  - Entering SET_H clears `cnt` and freezes time.
  - Leaving SET_S returns to RUN with `cnt = 0`.
- In set modes, `key_inc` increments only the selected field:
  - wraps per field (H 23→00, M/S 59→00)
  - no carry into the neighbouring field
- `key_inc` is ignored in RUN.
- `key_mode` and `key_inc` in the same cycle: `key_mode` wins, `key_inc` is discarded.
- `Twinkle_en`: 000 in RUN; 100 / 010 / 001 in SET_H / SET_M / SET_S.
- `DTube_en` is constant 111 (all digits lit; blinking is handled downstream).
- All outputs are registered.

## Timing
- Reset values:
  - `number_BCD` = 24'h000000 (24'h120000 with HOUR12_EN)
  - `DTube_en` = 3'b111
  - `Twinkle_en` = 3'b000
  - `mode` = 0
  - `tick_1hz` = 0
  - `cnt` = 0
- Reset mid-operation: all state returns to reset values immediately (asynchronously). Counting restarts on the first clock edge after release.
- First second after reset release: `number_BCD` = ..01 and `tick_1hz` = 1, both visible after exactly CLK_DIV rising edges.
- Latency is 1 cycle from key pulse to the `mode`, `Twinkle_en` and `number_BCD` update.
- Re-entering RUN restarts the full CLK_DIV period; the first advance comes CLK_DIV edges later.
- `tick_1hz` never pulses outside RUN.
- Key pulse exactly on the prescaler terminal edge in RUN: `key_mode` takes effect, and the second advance on that same edge also commits.

## Configuration
- `DIGITAL_CLOCK_HOUR12_EN`: when defined, hours run in 12-hour form.
  - Range is 01..12; reset value is 12:00:00.
  - Running wrap is 12→01.
  - SET_H increment wraps 12→01.
  - There is no AM/PM indicator.
- When undefined: 24-hour form as described above.

## Test plan
- Reset and count, CLK_DIV=4:
  - hold `rst_N`=1 → `number_BCD`=000000, `DTube_en`=111, `Twinkle_en`=000
  - release → ..01 after 4 edges, ..02 after 8 edges, with one `tick_1hz` pulse each
- Cascade wrap: set 23:59:59, run one period → 00:00:00 with a single `tick_1hz`; 09:59:59 → 10:00:00.
- Set mode:
  - 3×`key_mode` → `mode` 1/2/3, `Twinkle_en` 100/010/001
  - in SET_M from 00:59:30, one `key_inc` → 00:00:30 (no hour carry)
  - 4th `key_mode` → RUN, `Twinkle_en` 000
- Freeze: in SET_S idle for 10×CLK_DIV cycles → `number_BCD` unchanged, no `tick_1hz`.
- Collision:
  - `key_mode`+`key_inc` same cycle in SET_H → mode=2, hours unchanged
  - `key_inc` in RUN → no change
- Async reset mid-SET_M: assert `rst_N` between edges → outputs at reset values before the next edge.
- With DIGITAL_CLOCK_HOUR12_EN: reset → 120000; 12:59:59 + one period → 01:00:00.
